// File: rtl/wb_arbiter.sv
// Two-requester round-robin arbiter in front of a single Wishbone master port.
// One transaction is outstanding at a time. Each grant is held until wb_ack
// arrives or the bus timeout expires, and every grant returns through IDLE.
module wb_arbiter #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic        m0_wen,
  input  logic        m0_ren,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_wen,
  input  logic        m1_ren,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        m1_err,
  output logic [31:0] wb_addro,
  output logic [31:0] wb_do,
  output logic [3:0]  wb_sel,
  output logic        wb_wen,
  output logic        wb_ren,
  input  logic [31:0] wb_di,
  input  logic        wb_ack,
  output logic        busy,
  output logic        grant_id
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  // Last count value before the transaction is force-terminated.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [7:0]  to_cnt_q, to_cnt_d;

  logic        req0, req1;
  logic        gsel;
  logic        greq, gwen, gren;
  logic [31:0] gaddr, gwdata;
  logic        done_ack, done_err;
  logic [31:0] done_data;

  assign req0 = m0_wen | m0_ren;
  assign req1 = m1_wen | m1_ren;

  // Requester currently owning the bus; only meaningful in a grant state.
  assign gsel   = (state_q == GNT1);
  assign greq   = gsel ? req1     : req0;
  assign gwen   = gsel ? m1_wen   : m0_wen;
  assign gren   = gsel ? m1_ren   : m0_ren;
  assign gaddr  = gsel ? m1_addr  : m0_addr;
  assign gwdata = gsel ? m1_wdata : m0_wdata;

  assign wb_sel   = 4'b1111;
  assign busy     = (state_q != IDLE);
  assign grant_id = busy ? gsel : last_grant_q;

  // State, fairness pointer and timeout counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      to_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      to_cnt_q     <= to_cnt_d;
    end
  end

  // Next-state logic, bus drive and completion/timeout decode.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    to_cnt_d     = to_cnt_q;
    wb_addro     = '0;
    wb_do        = '0;
    wb_wen       = 1'b0;
    wb_ren       = 1'b0;
    done_ack     = 1'b0;
    done_err     = 1'b0;
    done_data    = '0;
    unique case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (req0 && req1) state_d = last_grant_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0, GNT1: begin
        wb_addro = gaddr;
        wb_do    = gwdata;
        wb_wen   = gwen;
        wb_ren   = gren & ~gwen;
        if (!greq) begin
          // Requester withdrew: drop the grant silently, fairness untouched.
          state_d  = IDLE;
          to_cnt_d = '0;
        end else if (wb_ack) begin
          // A real ack wins over a timeout landing in the same cycle.
          done_ack     = 1'b1;
          done_data    = wb_di;
          state_d      = IDLE;
          last_grant_d = gsel;
          to_cnt_d     = '0;
        end else if (to_cnt_q == TO_LAST) begin
          done_ack     = 1'b1;
          done_err     = 1'b1;
          done_data    = TIMEOUT_DATA;
          state_d      = IDLE;
          last_grant_d = gsel;
          to_cnt_d     = '0;
        end else begin
          to_cnt_d = to_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Route the completion only to the granted requester.
  always_comb begin
    m0_ack   = done_ack & ~gsel;
    m0_err   = done_err & ~gsel;
    m0_rdata = gsel ? 32'h0 : done_data;
    m1_ack   = done_ack & gsel;
    m1_err   = done_err & gsel;
    m1_rdata = gsel ? done_data : 32'h0;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Two-requester arbiter sharing the single Wishbone master port to external RAM.
- Requester 0 is the CPU path, i.e. the MMIO default/RAM branch. Requester 1 is a DMA or fetch engine, for example a DPU sprite/framebuffer loader.
- Fair round-robin grant. Each granted transaction is held until ack, so only one transaction is outstanding at a time. A bus timeout prevents a lost ack from hanging the CPU.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in a grant state without wb_ack before the arbiter force-terminates the transaction.
- TIMEOUT_DATA, 32'hDEADBEEF: read data returned to the requester on timeout.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_addr  in  32  requester 0 address
- m0_wdata  in  32  requester 0 write data
- m0_wen  in  1  requester 0 write request
- m0_ren  in  1  requester 0 read request
- m0_rdata  out  32  requester 0 read data
- m0_ack  out  1  requester 0 transaction done, 1-cycle pulse
- m0_err  out  1  requester 0 timeout flag, pulses with m0_ack
- m1_addr, m1_wdata, m1_wen, m1_ren, m1_rdata, m1_ack, m1_err: same as requester 0, for requester 1
- wb_addro  out  32  bus address
- wb_do  out  32  bus write data
- wb_sel  out  4  constant 4'b1111
- wb_wen  out  1  bus write enable
- wb_ren  out  1  bus read enable
- wb_di  in  32  bus read data
- wb_ack  in  1  bus ack
- busy  out  1  high in any grant state
- grant_id  out  1  index of the granted/last-granted requester

Behaviour:
- Request definitions: reqX = mX_wen | mX_ren. Each requester holds address, data and enables stable until mX_ack.
- State register: IDLE, GNT0, GNT1. Also last_grant (1 bit) and to_cnt (8 bits, sized for TIMEOUT_CYCLES).
- Reset values: state=IDLE, last_grant=1 (requester 0 wins the first tie), to_cnt=0.
- Outputs during and after reset: all wb_* outputs 0 except wb_sel=4'b1111; all mX_ack, mX_err = 0; mX_rdata = 0; busy=0; grant_id=last_grant.
- IDLE transitions:
  - only req0 -> GNT0
  - only req1 -> GNT1
  - both -> grant the requester != last_grant
  - none -> stay in IDLE
  - No bus signals are driven in IDLE.
- GNTx bus drive (combinational from state): wb_addro=mX_addr, wb_do=mX_wdata, wb_wen=mX_wen, wb_ren=mX_ren & ~mX_wen. Write wins if both enables are high.
- GNTx, completion: wb_ack=1 -> mX_ack=1 and mX_rdata=wb_di that same cycle; next state IDLE; last_grant<=x; to_cnt<=0.
- GNTx, timeout: to_cnt==TIMEOUT_CYCLES-1 without ack -> mX_ack=1, mX_err=1, mX_rdata=TIMEOUT_DATA; wb enables stay as driven; next state IDLE; last_grant<=x; to_cnt<=0.
- GNTx, otherwise: to_cnt increments.
- Latency: request visible in cycle N -> bus driven from cycle N+1. Minimum of 2 cycles from request to ack with zero-wait RAM.
  - Because every transaction returns through IDLE, back-to-back transactions are spaced at least 1 idle cycle.
- Abort: requester drops reqX in GNTx before ack -> return to IDLE; no ack, no err; last_grant unchanged.
- Non-granted requester: mY_ack=0 and mY_rdata=0 always.
- Stray wb_ack arriving in IDLE is ignored.
- Simultaneous ack and timeout in the same cycle: ack wins, err=0, real data returned.
- Reset mid-transaction: immediately IDLE with all outputs at reset values. The in-flight transaction is lost and no ack is issued.
- grant_id = x in GNTx, last_grant in IDLE. busy = (state != IDLE).

Test Plan:
- Single read: m0_ren=1, m0_addr=32'h0000_0100; RAM acks 2 cycles later with wb_di=32'h1234_5678 -> wb_ren high from cycle 1; m0_ack pulses exactly once with m0_rdata=32'h1234_5678; busy returns to 0 the next cycle.
- Contention and round-robin: both requesters hold a read from reset, zero-wait RAM -> grant order 0,1,0,1. m1_ack never coincides with m0_ack. wb_addro alternates between m0_addr and m1_addr.
- Write priority: m1_wen=1 and m1_ren=1, m1_wdata=32'hCAFE_F00D -> wb_wen=1, wb_ren=0, wb_do=32'hCAFE_F00D; m1_ack on RAM ack.
- Timeout: m0_ren=1, RAM never acks, TIMEOUT_CYCLES=8 -> m0_ack=m0_err=1 in the 8th grant cycle with m0_rdata=32'hDEADBEEF; state returns to IDLE; a following request from requester 1 is granted.
- Abort and stray ack: m1_ren drops after 1 grant cycle -> IDLE, no m1_ack, next tie still goes to requester 1. A wb_ack pulse in IDLE -> no ack to either requester.
- Reset mid-grant: rst asserted asynchronously during GNT0 -> wb_ren falls to 0 before the next clock edge; state=IDLE; first post-reset tie grants requester 0.
